l1_coherent_cache: RTL and testbench
====================================

// Module: l1_coherent_cache
// PURPOSE
//   Private L1 data cache for one processor in the 2-core directory-coherence system.
//   Direct-mapped, 2 lines of 8-bit data, MSI states per line; misses and upgrades go to the
//   shared L2/directory, which also forwards fetch/invalidate snoops and peer data back.
//   Two instances: core 0 and core 1, each cross-wired through the L2 to the other.
// PARAMETERS
//   NUM_LINES   2   lines; index = address[0]; full 8-bit address kept as tag
//   DATA_W      8   data/address width
// PORTS
//   clk               in   1  single clock, rising edge
//   rst               in   1  asynchronous, active-high reset
//   proc_addr         in   8  processor address, held stable by processor until serviced
//   proc_op           in   1  0 = read, 1 = write
//   proc_wdata        in   8  processor write data
//   abort_in          in   1  L2: fill data comes from peer cache, not memory
//   reply_data        in   8  fill data from L2
//   snoop_cmd         in   3  directory command (see BEHAVIOUR)
//   reply_kind        in   3  001 fill-shared, 010 fill-modified, others = no reply
//   snoop_addr        in   8  address targeted by snoop_cmd
//   abort_out         out  1  this cache supplies data for current snoop
//   proc_rdata        out  8  read/written data to processor (also visible to L2)
//   supply_data       out  8  data for snoop supply or write-back
//   wb_valid          out  1  1-cycle pulse: dirty victim written back
//   req_cmd           out  3  request to directory
//   req_addr          out  8  address of req_cmd / write-back
// BEHAVIOUR
//   - State enc: 00 Invalid, 10 Shared, 11 Modified; 01 treated as Invalid.
//   - req_cmd: 000 NONE, 001 READ_MISS, 010 WRITE_MISS, 011 UPGRADE, 100 WRITE_BACK.
//   - snoop_cmd: 000 NONE, 001 FETCH (M->S), 010 INVALIDATE (->I), 011 FETCH_INV (M->I).
//   - Reset: all lines Invalid, tags/data 0, every output 0, FSM IDLE.
//   - Arrays named tag[], data[], coherencyStates[] (bench preloads by hierarchy).
//   - FSM IDLE, WB, MISS_WAIT, FILL. All outputs registered; req_cmd/wb_valid 1-cycle pulses.
//   - IDLE hit (tag==addr, state!=I): read -> proc_rdata=data next cycle; write in M ->
//     data updated, proc_rdata=wdata; write in S -> data updated, state M, req_cmd UPGRADE.
//   - IDLE miss, victim M: -> WB: wb_valid=1, req_cmd WRITE_BACK, req_addr=victim tag,
//     supply_data=victim data; line -> I; then issue miss next cycle.
//   - Miss issue: req_cmd READ_MISS/WRITE_MISS, req_addr=proc_addr; -> MISS_WAIT.
//   - MISS_WAIT: hold until reply_kind 001/010; FILL writes tag=addr, data=reply_data,
//     state S (001) or M (010); pending write merges wdata, forces M; back to IDLE,
//     request re-evaluates as hit. abort_in only informational (same data path).
//   - Snoop: one cycle, priority over processor access in same cycle; acts only if
//     snoop_addr matches valid tag. FETCH/FETCH_INV on M: supply_data=data, abort_out=1.
//     No match: abort_out=0, no state change. Snoop on line in WB is ignored (already I).
//   - Snoop INVALIDATE during MISS_WAIT on the same address: fill still completes.
//   - Reset mid-miss: returns to IDLE, pending request dropped.
// STRUCTURE
//   Package coh_pkg: state, req_cmd, snoop_cmd, reply_kind enums; NUM_LINES, DATA_W.
//   Sub-module l1_line_store: tag/data/state arrays, one write port, hit/victim lookup.
// TESTING
//   - Reset, preload line0 {tag 00,data 10,M}: read addr 00 -> proc_rdata 10, no req_cmd.
//   - Preload line1 {tag 01,S}: write 01 data 55 -> req_cmd UPGRADE, state M, data 55.
//   - Read 02 with line0 M (data 10): WRITE_BACK addr 00 supply 10 wb_valid, then
//     READ_MISS 02; reply_kind 001 data 68 -> line0 {02,68,S}, proc_rdata 68.
//   - snoop FETCH addr 00 on M line data 10 -> abort_out 1, supply 10, state S.
//   - snoop INVALIDATE addr 03, no match -> no change; match S -> Invalid.
//   - Write miss addr 04 data 7F, reply 010 data 00 -> line0 {04,7F,M}; rst mid-wait -> all I.

Source files
------------

// File: rtl/coh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coh_pkg
//  Description : Shared types and sizes for the L1 MSI coherent cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package coh_pkg;

    localparam int NUM_LINES = 2;
    localparam int DATA_W    = 8;
    localparam int IDX_W     = $clog2(NUM_LINES);

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_X = 2'b01,
        MSI_S = 2'b10,
        MSI_M = 2'b11
    } msi_e;

    typedef enum logic [2:0] {
        REQ_NONE       = 3'b000,
        REQ_READ_MISS  = 3'b001,
        REQ_WRITE_MISS = 3'b010,
        REQ_UPGRADE    = 3'b011,
        REQ_WRITE_BACK = 3'b100
    } req_cmd_e;

    typedef enum logic [2:0] {
        SNP_NONE       = 3'b000,
        SNP_FETCH      = 3'b001,
        SNP_INVALIDATE = 3'b010,
        SNP_FETCH_INV  = 3'b011
    } snoop_cmd_e;

    typedef enum logic [2:0] {
        RPL_NONE   = 3'b000,
        RPL_FILL_S = 3'b001,
        RPL_FILL_M = 3'b010
    } reply_kind_e;

    // Encoding 01 is not a legal MSI state and is treated as Invalid.
    function automatic logic isValid(input logic [1:0] st);
        return st[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_coherent_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : l1_coherent_cache_if
//  Description : Processor / L2-directory bus seen by one L1 cache instance.
//  Revision    : 1.0 - initial release
// ============================================================================
interface l1_coherent_cache_if;
    import coh_pkg::*;

    logic [DATA_W-1:0] proc_addr;
    logic              proc_op;
    logic [DATA_W-1:0] proc_wdata;
    logic              abort_in;
    logic [DATA_W-1:0] reply_data;
    logic [2:0]        snoop_cmd;
    logic [2:0]        reply_kind;
    logic [DATA_W-1:0] snoop_addr;
    logic              abort_out;
    logic [DATA_W-1:0] proc_rdata;
    logic [DATA_W-1:0] supply_data;
    logic              wb_valid;
    logic [2:0]        req_cmd;
    logic [DATA_W-1:0] req_addr;

    modport slave (
        input  proc_addr, proc_op, proc_wdata, abort_in, reply_data,
               snoop_cmd, reply_kind, snoop_addr,
        output abort_out, proc_rdata, supply_data, wb_valid, req_cmd, req_addr
    );

    modport master (
        output proc_addr, proc_op, proc_wdata, abort_in, reply_data,
               snoop_cmd, reply_kind, snoop_addr,
        input  abort_out, proc_rdata, supply_data, wb_valid, req_cmd, req_addr
    );

endinterface
`default_nettype wire

// File: rtl/l1_line_store.sv
`default_nettype none
// ============================================================================
//  Module      : l1_line_store
//  Description : Tag/data/MSI arrays with one write port and two lookups
//                (processor address and snoop address).
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_line_store
    import coh_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [DATA_W-1:0] i_lookupAddr,
    output logic                   o_lookupHit,
    output logic [1:0]             o_lookupState,
    output logic [DATA_W-1:0]      o_lookupTag,
    output logic [DATA_W-1:0]      o_lookupData,
    input  wire logic [DATA_W-1:0] i_snoopAddr,
    output logic                   o_snoopHit,
    output logic [1:0]             o_snoopState,
    output logic [DATA_W-1:0]      o_snoopData,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_wIdx,
    input  wire logic [DATA_W-1:0] i_wTag,
    input  wire logic [DATA_W-1:0] i_wData,
    input  wire logic [1:0]        i_wState
);

    logic [DATA_W-1:0] tag             [NUM_LINES];
    logic [DATA_W-1:0] data            [NUM_LINES];
    logic [1:0]        coherencyStates [NUM_LINES];

    logic [IDX_W-1:0] w_lkIdx;
    logic [IDX_W-1:0] w_snIdx;

    assign w_lkIdx = i_lookupAddr[IDX_W-1:0];
    assign w_snIdx = i_snoopAddr[IDX_W-1:0];

    // The full address is kept as tag, so a hit compares all address bits.
    assign o_lookupState = coherencyStates[w_lkIdx];
    assign o_lookupTag   = tag[w_lkIdx];
    assign o_lookupData  = data[w_lkIdx];
    assign o_lookupHit   = isValid(coherencyStates[w_lkIdx]) && (tag[w_lkIdx] == i_lookupAddr);

    assign o_snoopState  = coherencyStates[w_snIdx];
    assign o_snoopData   = data[w_snIdx];
    assign o_snoopHit    = isValid(coherencyStates[w_snIdx]) && (tag[w_snIdx] == i_snoopAddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag[i]             <= '0;
                data[i]            <= '0;
                coherencyStates[i] <= MSI_I;
            end
        end else if (i_we) begin
            tag[i_wIdx]             <= i_wTag;
            data[i_wIdx]            <= i_wData;
            coherencyStates[i_wIdx] <= i_wState;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1_coherent_cache.sv
`default_nettype none
// ============================================================================
//  Module      : l1_coherent_cache
//  Description : Direct-mapped MSI L1 data cache with directory requests,
//                dirty write-back and single-cycle snoop handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_coherent_cache
    import coh_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    l1_coherent_cache_if.slave bus
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WB        = 2'd1;
    localparam logic [1:0] c_MISS_WAIT = 2'd2;
    localparam logic [1:0] c_FILL      = 2'd3;

    logic [1:0]        r_state,      w_stateNext;
    logic [DATA_W-1:0] r_procRdata,  w_procRdataNext;
    logic [DATA_W-1:0] r_supplyData, w_supplyNext;
    logic [DATA_W-1:0] r_reqAddr,    w_reqAddrNext;
    logic [2:0]        r_reqCmd,     w_reqCmdNext;
    logic              r_wbValid,    w_wbValidNext;
    logic              r_abortOut,   w_abortNext;
    logic [DATA_W-1:0] r_fillData,   w_fillDataNext;
    logic              r_fillM,      w_fillMNext;

    logic              w_lkHit;
    logic [1:0]        w_lkState;
    logic [DATA_W-1:0] w_lkTag;
    logic [DATA_W-1:0] w_lkData;
    logic              w_snHit;
    logic [1:0]        w_snState;
    logic [DATA_W-1:0] w_snData;
    logic              w_snoopAct;
    logic              w_we;
    logic [IDX_W-1:0]  w_wIdx;
    logic [DATA_W-1:0] w_wTag;
    logic [DATA_W-1:0] w_wData;
    logic [1:0]        w_wState;
    logic [DATA_W-1:0] w_fillMerged;

    l1_line_store u_store (
        .clk           (clk),
        .rst           (rst),
        .i_lookupAddr  (bus.proc_addr),
        .o_lookupHit   (w_lkHit),
        .o_lookupState (w_lkState),
        .o_lookupTag   (w_lkTag),
        .o_lookupData  (w_lkData),
        .i_snoopAddr   (bus.snoop_addr),
        .o_snoopHit    (w_snHit),
        .o_snoopState  (w_snState),
        .o_snoopData   (w_snData),
        .i_we          (w_we),
        .i_wIdx        (w_wIdx),
        .i_wTag        (w_wTag),
        .i_wData       (w_wData),
        .i_wState      (w_wState)
    );

    assign w_snoopAct = w_snHit && ((bus.snoop_cmd == SNP_FETCH) ||
                                    (bus.snoop_cmd == SNP_INVALIDATE) ||
                                    (bus.snoop_cmd == SNP_FETCH_INV));

    // A pending write merges into the fill, which makes the line Modified.
    assign w_fillMerged = bus.proc_op ? bus.proc_wdata : r_fillData;

    always_comb begin
        w_stateNext     = r_state;
        w_procRdataNext = r_procRdata;
        w_supplyNext    = r_supplyData;
        w_reqAddrNext   = r_reqAddr;
        w_reqCmdNext    = REQ_NONE;
        w_wbValidNext   = 1'b0;
        w_abortNext     = 1'b0;
        w_fillDataNext  = r_fillData;
        w_fillMNext     = r_fillM;
        w_we            = 1'b0;
        w_wIdx          = bus.proc_addr[IDX_W-1:0];
        w_wTag          = w_lkTag;
        w_wData         = w_lkData;
        w_wState        = w_lkState;

        // The snoop owns the write port for its cycle; processor work waits.
        if (w_snoopAct) begin
            w_we     = 1'b1;
            w_wIdx   = bus.snoop_addr[IDX_W-1:0];
            w_wTag   = bus.snoop_addr;
            w_wData  = w_snData;
            w_wState = w_snState;
            if ((bus.snoop_cmd != SNP_INVALIDATE) && (w_snState == MSI_M)) begin
                w_supplyNext = w_snData;
                w_abortNext  = 1'b1;
            end
            case (bus.snoop_cmd)
                SNP_FETCH:      if (w_snState == MSI_M) w_wState = MSI_S;
                SNP_INVALIDATE: w_wState = MSI_I;
                SNP_FETCH_INV:  w_wState = MSI_I;
                default:        w_wState = w_snState;
            endcase
        end

        case (r_state)
            c_IDLE: begin
                if (!w_snoopAct) begin
                    if (w_lkHit) begin
                        if (!bus.proc_op) begin
                            w_procRdataNext = w_lkData;
                        end else begin
                            w_procRdataNext = bus.proc_wdata;
                            w_we            = 1'b1;
                            w_wTag          = bus.proc_addr;
                            w_wData         = bus.proc_wdata;
                            w_wState        = MSI_M;
                            if (w_lkState == MSI_S) begin
                                w_reqCmdNext  = REQ_UPGRADE;
                                w_reqAddrNext = bus.proc_addr;
                            end
                        end
                    end else if (w_lkState == MSI_M) begin
                        w_we          = 1'b1;
                        w_wState      = MSI_I;
                        w_wbValidNext = 1'b1;
                        w_reqCmdNext  = REQ_WRITE_BACK;
                        w_reqAddrNext = w_lkTag;
                        w_supplyNext  = w_lkData;
                        w_stateNext   = c_WB;
                    end else begin
                        w_reqCmdNext  = bus.proc_op ? REQ_WRITE_MISS : REQ_READ_MISS;
                        w_reqAddrNext = bus.proc_addr;
                        w_stateNext   = c_MISS_WAIT;
                    end
                end
            end
            c_WB: begin
                w_reqCmdNext  = bus.proc_op ? REQ_WRITE_MISS : REQ_READ_MISS;
                w_reqAddrNext = bus.proc_addr;
                w_stateNext   = c_MISS_WAIT;
            end
            c_MISS_WAIT: begin
                if ((bus.reply_kind == RPL_FILL_S) || (bus.reply_kind == RPL_FILL_M)) begin
                    w_fillDataNext = bus.reply_data;
                    w_fillMNext    = (bus.reply_kind == RPL_FILL_M);
                    w_stateNext    = c_FILL;
                end
            end
            c_FILL: begin
                if (!w_snoopAct) begin
                    w_we            = 1'b1;
                    w_wTag          = bus.proc_addr;
                    w_wData         = w_fillMerged;
                    w_wState        = (bus.proc_op || r_fillM) ? MSI_M : MSI_S;
                    w_procRdataNext = w_fillMerged;
                    w_stateNext     = c_IDLE;
                end
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_procRdata  <= '0;
            r_supplyData <= '0;
            r_reqAddr    <= '0;
            r_reqCmd     <= REQ_NONE;
            r_wbValid    <= 1'b0;
            r_abortOut   <= 1'b0;
            r_fillData   <= '0;
            r_fillM      <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_procRdata  <= w_procRdataNext;
            r_supplyData <= w_supplyNext;
            r_reqAddr    <= w_reqAddrNext;
            r_reqCmd     <= w_reqCmdNext;
            r_wbValid    <= w_wbValidNext;
            r_abortOut   <= w_abortNext;
            r_fillData   <= w_fillDataNext;
            r_fillM      <= w_fillMNext;
        end
    end

    assign bus.proc_rdata  = r_procRdata;
    assign bus.supply_data = r_supplyData;
    assign bus.req_addr    = r_reqAddr;
    assign bus.req_cmd     = r_reqCmd;
    assign bus.wb_valid    = r_wbValid;
    assign bus.abort_out   = r_abortOut;

endmodule
`default_nettype wire

// File: tb/tb_l1_coherent_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_coherent_cache
//  Description : Directed scoreboard bench for the L1 MSI coherent cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_coherent_cache;
    import coh_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_coherent_cache_if bus();
    l1_coherent_cache dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       isSnoop;
        logic [2:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t expQ[$];
    int   errors  = 0;
    int   checks  = 0;
    int   evCount = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushReq(input logic [2:0] cmd, input logic [7:0] addr, input logic [7:0] d);
        exp_t e;
        e.isSnoop = 1'b0; e.cmd = cmd; e.addr = addr; e.data = d;
        expQ.push_back(e);
    endtask

    task automatic pushSupply(input logic [7:0] d);
        exp_t e;
        e.isSnoop = 1'b1; e.cmd = 3'b000; e.addr = 8'h00; e.data = d;
        expQ.push_back(e);
    endtask

    // Monitor: every request pulse or snoop supply is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (bus.req_cmd !== 3'b000 || bus.wb_valid !== 1'b0) begin
                evCount++;
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got cmd %0d addr %h expected none", bus.req_cmd, bus.req_addr);
                end else begin
                    e = expQ.pop_front();
                    check8("req_is_request", {7'b0, bus.abort_out & e.isSnoop}, 8'h00);
                    check8("req_cmd", {5'b0, bus.req_cmd}, {5'b0, e.cmd});
                    check8("req_addr", bus.req_addr, e.addr);
                    check8("wb_valid", {7'b0, bus.wb_valid}, {7'b0, (e.cmd == 3'b100)});
                    if (e.cmd == 3'b100) check8("wb_supply", bus.supply_data, e.data);
                end
            end
            if (bus.abort_out !== 1'b0) begin
                evCount++;
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_abort: got supply %h expected none", bus.supply_data);
                end else begin
                    e = expQ.pop_front();
                    check8("abort_expected", {7'b0, e.isSnoop}, 8'h01);
                    check8("snoop_supply", bus.supply_data, e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitEv(input int target, input string name);
        int t = 0;
        while (evCount < target && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (evCount < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d events expected %0d", name, evCount, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reply(input logic [2:0] kind, input logic [7:0] d);
        bus.reply_kind = kind;
        bus.reply_data = d;
        tick(1);
        bus.reply_kind = 3'b000;
    endtask

    task automatic snoop(input logic [2:0] cmd, input logic [7:0] addr);
        bus.snoop_cmd  = cmd;
        bus.snoop_addr = addr;
        tick(1);
        bus.snoop_cmd  = 3'b000;
    endtask

    task automatic checkLine(input string name, input int idx, input logic [7:0] t,
                             input logic [7:0] d, input logic [1:0] st);
        check8({name, "_tag"},   dut.u_store.tag[idx], t);
        check8({name, "_data"},  dut.u_store.data[idx], d);
        check8({name, "_state"}, {6'b0, dut.u_store.coherencyStates[idx]}, {6'b0, st});
    endtask

    initial begin
        rst = 1'b1;
        bus.proc_op = 1'b1; bus.proc_addr = 8'h00; bus.proc_wdata = 8'h10;
        bus.abort_in = 1'b0; bus.reply_data = 8'h00; bus.reply_kind = 3'b000;
        bus.snoop_cmd = 3'b000; bus.snoop_addr = 8'h00;
        tick(2);
        check8("rst_req_cmd", {5'b0, bus.req_cmd}, 8'h00);
        check8("rst_wb_valid", {7'b0, bus.wb_valid}, 8'h00);
        check8("rst_abort_out", {7'b0, bus.abort_out}, 8'h00);
        check8("rst_proc_rdata", bus.proc_rdata, 8'h00);
        check8("rst_supply", bus.supply_data, 8'h00);
        check8("rst_req_addr", bus.req_addr, 8'h00);
        check8("rst_state0", {6'b0, dut.u_store.coherencyStates[0]}, 8'h00);
        check8("rst_state1", {6'b0, dut.u_store.coherencyStates[1]}, 8'h00);

        // Bring line0 to {00,10,M} through a write miss filled as modified.
        pushReq(3'b010, 8'h00, 8'h00);
        rst = 1'b0;
        waitEv(1, "wmiss00");
        reply(3'b010, 8'h00);
        tick(3);
        checkLine("line0_wfill", 0, 8'h00, 8'h10, 2'b11);
        check8("rdata_wfill", bus.proc_rdata, 8'h10);

        // Read hit on M line: data returned, no request.
        bus.proc_op = 1'b0; bus.proc_addr = 8'h00;
        tick(3);
        check8("rdata_hit00", bus.proc_rdata, 8'h10);

        // Read miss 01 with a non-matching invalidate during the wait.
        pushReq(3'b001, 8'h01, 8'h00);
        bus.proc_addr = 8'h01;
        waitEv(2, "rmiss01");
        snoop(3'b010, 8'h01);
        reply(3'b001, 8'h33);
        tick(3);
        checkLine("line1_rfill", 1, 8'h01, 8'h33, 2'b10);
        check8("rdata_rfill", bus.proc_rdata, 8'h33);

        // Write hit on S line: upgrade.
        pushReq(3'b011, 8'h01, 8'h00);
        bus.proc_op = 1'b1; bus.proc_wdata = 8'h55;
        waitEv(3, "upgrade");
        tick(2);
        checkLine("line1_upg", 1, 8'h01, 8'h55, 2'b11);
        check8("rdata_upg", bus.proc_rdata, 8'h55);

        // Read 02 conflicts with dirty line0: write-back then read miss.
        pushReq(3'b100, 8'h00, 8'h10);
        pushReq(3'b001, 8'h02, 8'h00);
        bus.proc_op = 1'b0; bus.proc_addr = 8'h02;
        waitEv(5, "wb_miss02");
        check8("line0_after_wb", {6'b0, dut.u_store.coherencyStates[0]}, 8'h00);
        reply(3'b001, 8'h68);
        tick(3);
        checkLine("line0_fill02", 0, 8'h02, 8'h68, 2'b10);
        check8("rdata_fill02", bus.proc_rdata, 8'h68);

        // FETCH on the M line 01.
        bus.proc_addr = 8'h01;
        tick(1);
        pushSupply(8'h55);
        snoop(3'b001, 8'h01);
        waitEv(6, "fetch01");
        checkLine("line1_fetch", 1, 8'h01, 8'h55, 2'b10);
        check8("rdata_read01", bus.proc_rdata, 8'h55);

        // INVALIDATE: miss leaves line1 alone, hit drops line0.
        snoop(3'b010, 8'h03);
        tick(2);
        check8("inv_nomatch", {6'b0, dut.u_store.coherencyStates[1]}, 8'h02);
        snoop(3'b010, 8'h02);
        tick(1);
        check8("inv_match", {6'b0, dut.u_store.coherencyStates[0]}, 8'h00);

        // Write miss 04: pending write overrides fill data.
        pushReq(3'b010, 8'h04, 8'h00);
        bus.proc_op = 1'b1; bus.proc_addr = 8'h04; bus.proc_wdata = 8'h7F;
        waitEv(7, "wmiss04");
        reply(3'b010, 8'h00);
        tick(3);
        checkLine("line0_fill04", 0, 8'h04, 8'h7F, 2'b11);
        check8("rdata_fill04", bus.proc_rdata, 8'h7F);

        // FETCH_INV on M line 04.
        bus.proc_op = 1'b0; bus.proc_addr = 8'h01;
        tick(1);
        pushSupply(8'h7F);
        snoop(3'b011, 8'h04);
        waitEv(8, "fetchinv04");
        check8("fetchinv_state", {6'b0, dut.u_store.coherencyStates[0]}, 8'h00);

        // Reset in the middle of a miss drops it.
        pushReq(3'b001, 8'h06, 8'h00);
        bus.proc_addr = 8'h06;
        waitEv(9, "rmiss06");
        rst = 1'b1;
        tick(2);
        check8("midrst_fsm", {6'b0, dut.r_state}, 8'h00);
        check8("midrst_state0", {6'b0, dut.u_store.coherencyStates[0]}, 8'h00);
        check8("midrst_state1", {6'b0, dut.u_store.coherencyStates[1]}, 8'h00);
        check8("midrst_req_cmd", {5'b0, bus.req_cmd}, 8'h00);
        check8("midrst_rdata", bus.proc_rdata, 8'h00);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
